muldiv_hilo: RTL and testbench
==============================

// Module: muldiv_hilo
// PURPOSE
//  Execute-stage MULT/MULTU/DIV/DIVU unit plus architectural HI/LO register pair.
//  Sits downstream of the pipeline controller: consumes decoded E-stage mul/div strobes,
//  returns a stall request to the hazard logic, and commits HI/LO at writeback on HiLoWriteW.
//  Multiply is single-cycle combinational; divide is a 32-iteration restoring divider.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO each WIDTH bits, product 2*WIDTH
//  DIV_ITERS WIDTH  divider iterations (must equal WIDTH)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  mul_startE   in   1      E-stage instr is MULT/MULTU
//  div_startE   in   1      E-stage instr is DIV/DIVU
//  signedE      in   1      1 = signed op (MULT/DIV), 0 = unsigned
//  srcaE        in   WIDTH  rs operand (dividend / multiplicand)
//  srcbE        in   WIDTH  rt operand (divisor / multiplier)
//  cancelE      in   1      flushE/exception: abort in-flight divide
//  stall_o      out  1      hold IF/ID/E stages while divide busy
//  result_hiE   out  WIDTH  HI result (product[63:32] / remainder)
//  result_loE   out  WIDTH  LO result (product[31:0] / quotient)
//  result_vldE  out  1      result_hiE/loE valid this cycle
//  HiLoWriteW   in   1      commit HI/LO this cycle
//  hi_inW       in   WIDTH  HI write data
//  lo_inW       in   WIDTH  LO write data
//  hi_o         out  WIDTH  current HI register
//  lo_o         out  WIDTH  current LO register
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, HI=LO=0, stall_o=0, result_vldE=0, results 0.
//  Multiply: mul_startE in IDLE -> result_vldE=1 same cycle, stall_o=0; signed uses
//   two's-complement 64-bit product, unsigned zero-extends. No state change.
//  Divide FSM states IDLE -> DIV -> DONE -> IDLE:
//   IDLE: div_startE & ~cancelE -> stall_o=1 (combinational), latch |a|,|b| (abs if
//    signedE), quotient/remainder sign flags, counter=0; next DIV.
//   DIV: one restoring shift-subtract step per cycle, counter++; stall_o=1;
//    after iteration DIV_ITERS (counter==DIV_ITERS-1) next DONE.
//   DONE: sign-corrected results driven, result_vldE=1, stall_o=0; next IDLE
//    unconditionally (div_startE still high this cycle must not restart).
//   Latency: stall_o high exactly 33 cycles (start cycle + 32), result in cycle 34.
//  Sign rules: quotient negative iff sign(a)^sign(b); remainder takes sign of a.
//  Divide by zero: no trap; LO=all-ones (unsigned) / as produced by algorithm, HI=a.
//   Bench checks exact: DIVU x/0 -> LO=0xFFFFFFFF, HI=x.
//  Signed overflow 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  mul_startE and div_startE both high: illegal from decode; div takes priority.
//  cancelE in any state: stall_o forced 0 same cycle, next state IDLE, result_vldE=0.
//  rst mid-divide: IDLE next edge, all outputs to reset values.
//  HI/LO: written on clk edge when HiLoWriteW; hi_o/lo_o show new value next cycle
//   (no write-through bypass; forwarding handled by hazard/forward logic).
//  Operands latched at start; srcaE/srcbE changes during DIV are ignored.
// TESTING
//  MULT 0xFFFFFFFF*0x00000002 signed -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, vld same cycle, no stall.
//  MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
//  DIV -7/2 signed -> stall 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  DIVU 100/0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  cancelE at DIV cycle 10 -> stall_o low same cycle, IDLE next, new DIVU 9/4 -> lo=2, hi=1.
//  HiLoWriteW with hi=0xA5A5A5A5, lo=0x5A5A5A5A -> hi_o/lo_o update next cycle; rst clears to 0.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// E-stage and W-stage signal bundle between the pipeline and the mul/div + HI/LO unit.
// The pipeline side drives operands and strobes; the unit side returns results, stall and HI/LO.
interface muldiv_hilo_if #(
   parameter int WIDTH = 32
);
   logic             mul_startE;
   logic             div_startE;
   logic             signedE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic             cancelE;
   logic             stall_o;
   logic [WIDTH-1:0] result_hiE;
   logic [WIDTH-1:0] result_loE;
   logic             result_vldE;
   logic             HiLoWriteW;
   logic [WIDTH-1:0] hi_inW;
   logic [WIDTH-1:0] lo_inW;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output mul_startE, div_startE, signedE, srcaE, srcbE, cancelE,
      output HiLoWriteW, hi_inW, lo_inW,
      input  stall_o, result_hiE, result_loE, result_vldE, hi_o, lo_o
   );

   modport slave (
      input  mul_startE, div_startE, signedE, srcaE, srcbE, cancelE,
      input  HiLoWriteW, hi_inW, lo_inW,
      output stall_o, result_hiE, result_loE, result_vldE, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_hilo.sv
// MULT/MULTU/DIV/DIVU execute unit with architectural HI/LO registers.
// Multiply is combinational; divide is a restoring shift-subtract FSM on operand magnitudes.
module muldiv_hilo #(
   parameter int WIDTH     = 32,
   parameter int DIV_ITERS = WIDTH
) (
   input logic         clk,
   input logic         rst,
   muldiv_hilo_if.slave bus
);
   localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   rem_sh;
   logic             fits;

   logic signed [2*WIDTH-1:0] opa_x;
   logic signed [2*WIDTH-1:0] opb_x;
   logic signed [2*WIDTH-1:0] prod;

   logic             stall;
   logic             vld;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
      return neg ? -mag : mag;
   endfunction

   // Sign-extending to 2*WIDTH lets one multiplier serve both signed and unsigned forms.
   assign opa_x = $signed({{WIDTH{bus.signedE & bus.srcaE[WIDTH-1]}}, bus.srcaE});
   assign opb_x = $signed({{WIDTH{bus.signedE & bus.srcbE[WIDTH-1]}}, bus.srcbE});
   assign prod  = opa_x * opb_x;

   assign a_abs  = magnitude(bus.srcaE, bus.signedE);
   assign b_abs  = magnitude(bus.srcbE, bus.signedE);
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign fits   = rem_sh >= {1'b0, dvs};

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.div_startE) state_nxt = S_DIV;
         S_DIV:   if (cnt == CNT_W'(DIV_ITERS - 1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (bus.cancelE) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE)
            cnt <= '0;
         else if (state == S_DIV)
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Divider datapath: quo doubles as the dividend shift register and collects quotient bits.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.div_startE && !bus.cancelE) begin
         rem   <= '0;
         quo   <= a_abs;
         dvs   <= b_abs;
         neg_q <= bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
         neg_r <= bus.signedE & bus.srcaE[WIDTH-1];
      end else if (state == S_DIV) begin
         rem <= fits ? rem_sh[WIDTH-1:0] - dvs : rem_sh[WIDTH-1:0];
         quo <= {quo[WIDTH-2:0], fits};
      end
   end

   always_comb begin
      stall  = 1'b0;
      vld    = 1'b0;
      res_hi = '0;
      res_lo = '0;
      if (!rst && !bus.cancelE) begin
         case (state)
            S_IDLE: begin
               if (bus.div_startE) begin
                  stall = 1'b1;
               end else if (bus.mul_startE) begin
                  vld    = 1'b1;
                  res_hi = prod[2*WIDTH-1:WIDTH];
                  res_lo = prod[WIDTH-1:0];
               end
            end
            S_DIV:  stall = 1'b1;
            S_DONE: begin
               vld    = 1'b1;
               res_hi = apply_sign(rem, neg_r);
               res_lo = apply_sign(quo, neg_q);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (bus.HiLoWriteW) begin
         hi_q <= bus.hi_inW;
         lo_q <= bus.lo_inW;
      end
   end

   assign bus.stall_o     = stall;
   assign bus.result_vldE = vld;
   assign bus.result_hiE  = res_hi;
   assign bus.result_loE  = res_lo;
   assign bus.hi_o        = hi_q;
   assign bus.lo_o        = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized bench for muldiv_hilo against a plain-arithmetic reference of MULT/DIV and HI/LO.
module tb_muldiv_hilo;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   muldiv_hilo_if #(.WIDTH(32)) bus ();

   muldiv_hilo #(.WIDTH(32), .DIV_ITERS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint x;
      longint y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return 64'(x * y);
   endfunction

   // Returns {HI, LO} = {remainder, quotient}.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint x;
      longint y;
      if (b == 32'd0 && !s) return {a, 32'hFFFF_FFFF};
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return {32'(x % y), 32'(x / y)};
   endfunction

   task automatic idle_inputs();
      bus.mul_startE = 1'b0;
      bus.div_startE = 1'b0;
      bus.signedE    = 1'b0;
      bus.cancelE    = 1'b0;
      bus.srcaE      = '0;
      bus.srcbE      = '0;
      bus.HiLoWriteW = 1'b0;
      bus.hi_inW     = '0;
      bus.lo_inW     = '0;
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [63:0] exp;
      exp = ref_mul(a, b, s);
      @(posedge clk); #1;
      bus.mul_startE = 1'b1;
      bus.signedE    = s;
      bus.srcaE      = a;
      bus.srcbE      = b;
      @(negedge clk);
      chk("mul_vld", 64'(bus.result_vldE), 64'd1);
      chk("mul_stall", 64'(bus.stall_o), 64'd0);
      chk("mul_hilo", {bus.result_hiE, bus.result_loE}, exp);
      @(posedge clk); #1;
      bus.mul_startE = 1'b0;
      @(negedge clk);
      chk("mul_after", {62'd0, bus.stall_o, bus.result_vldE}, 64'd0);
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [63:0] exp;
      int          stalls;
      bit          got;
      exp    = ref_div(a, b, s);
      stalls = 0;
      got    = 1'b0;
      @(posedge clk); #1;
      bus.div_startE = 1'b1;
      bus.signedE    = s;
      bus.srcaE      = a;
      bus.srcbE      = b;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (bus.result_vldE) begin
            got = 1'b1;
            chk("div_done_stall", 64'(bus.stall_o), 64'd0);
            chk("div_hilo", {bus.result_hiE, bus.result_loE}, exp);
            chk("div_stall_cycles", 64'(stalls), 64'd33);
         end else begin
            if (bus.stall_o) stalls++;
            @(posedge clk); #1;
            bus.srcaE = $urandom;
            bus.srcbE = $urandom;
         end
      end
      if (!got) chk("div_timeout", 64'd0, 64'd1);
      // div_startE was still high in the result cycle; it must not have re-armed the divider.
      @(posedge clk); #1;
      bus.div_startE = 1'b0;
      @(negedge clk);
      chk("div_no_restart", {62'd0, bus.stall_o, bus.result_vldE}, 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      n_vec = 0;
      n_err = 0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {60'd0, bus.stall_o, bus.result_vldE, 2'b00}, 64'd0);
      chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      chk("rst_res", {bus.result_hiE, bus.result_loE}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_mul(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      run_mul(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      run_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      run_div(32'd100, 32'd0, 1'b0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      // Abort a divide part-way through, then make sure a fresh one still works.
      @(posedge clk); #1;
      bus.div_startE = 1'b1;
      bus.signedE    = 1'b0;
      bus.srcaE      = 32'd1000;
      bus.srcbE      = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      bus.cancelE = 1'b1;
      @(negedge clk);
      chk("cancel_same_cycle", {62'd0, bus.stall_o, bus.result_vldE}, 64'd0);
      @(posedge clk); #1;
      bus.cancelE    = 1'b0;
      bus.div_startE = 1'b0;
      @(negedge clk);
      chk("cancel_idle", {62'd0, bus.stall_o, bus.result_vldE}, 64'd0);
      run_div(32'd9, 32'd4, 1'b0);

      // HI/LO commit is visible only after the write edge.
      @(posedge clk); #1;
      bus.HiLoWriteW = 1'b1;
      bus.hi_inW     = 32'hA5A5_A5A5;
      bus.lo_inW     = 32'h5A5A_5A5A;
      @(negedge clk);
      chk("hilo_no_bypass", {bus.hi_o, bus.lo_o}, 64'd0);
      @(posedge clk); #1;
      bus.HiLoWriteW = 1'b0;
      @(negedge clk);
      chk("hilo_write", {bus.hi_o, bus.lo_o}, 64'hA5A5_A5A5_5A5A_5A5A);

      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         @(posedge clk); #1;
         bus.HiLoWriteW = 1'b1;
         bus.hi_inW     = a;
         bus.lo_inW     = b;
         @(posedge clk); #1;
         bus.HiLoWriteW = 1'b0;
         @(negedge clk);
         chk("hilo_rand", {bus.hi_o, bus.lo_o}, {a, b});
      end

      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         s = 1'($urandom_range(0, 1));
         run_mul(a, b, s);
      end

      for (int i = 0; i < 8; i++) begin
         a = $urandom >> $urandom_range(0, 16);
         if (i[0]) a = -a;
         b = $urandom >> $urandom_range(8, 31);
         s = 1'(i % 3 != 0);
         if (i[1] && s) b = -b;
         if (s && b == 32'd0) b = 32'd3;
         run_div(a, b, s);
      end

      // Reset in the middle of a divide clears everything, including HI/LO.
      @(posedge clk); #1;
      bus.HiLoWriteW = 1'b1;
      bus.hi_inW     = 32'h1234_5678;
      bus.lo_inW     = 32'h9ABC_DEF0;
      bus.div_startE = 1'b1;
      bus.signedE    = 1'b1;
      bus.srcaE      = 32'd12345;
      bus.srcbE      = 32'd11;
      @(posedge clk); #1;
      bus.HiLoWriteW = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst            = 1'b0;
      bus.div_startE = 1'b0;
      @(negedge clk);
      chk("rst_mid_div", {62'd0, bus.stall_o, bus.result_vldE}, 64'd0);
      chk("rst_mid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit exceeded");
   end
endmodule
